// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register and retired-fetch counter.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        misalign_err,
`endif
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] ifpc4_q, ifpc4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus4;
    logic        frozen;
    logic        bad_target;

    assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic err_q, err_d;

    assign frozen       = err_q;
    assign bad_target   = (branch_target[1:0] != 2'b00);
    assign misalign_err = err_q;
`else
    assign frozen     = 1'b0;
    assign bad_target = 1'b0;
`endif

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        ifpc4_d = ifpc4_q;
        valid_d = valid_q;
        count_d = count_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        err_d   = err_q;
`endif
        if (frozen) begin
            // Trapped: behave as a permanent stall with nothing valid downstream.
            valid_d = 1'b0;
        end else if (branch_taken) begin
            if (bad_target) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                err_d = 1'b1;
`endif
            end else begin
                pc_d = {branch_target[31:2], 2'b00};
            end
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!stall) begin
            pc_d    = pc_plus4;
            instr_d = imem_instr;
            ifpc_d  = pc_q;
            ifpc4_d = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ifpc_q  <= 32'd0;
            ifpc4_q <= 32'd0;
            valid_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            ifpc4_q <= ifpc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = ifpc_q;
    assign if_id_pc4   = ifpc4_q;
    assign if_id_valid = valid_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle comparison against a behavioural model
// plus directed literal checks. Honours FETCH_MISALIGN_TRAP_EN like the design.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] fetch_count;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    // Instruction memory contents: a distinct, easily recognised word per address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign imem_instr = word(imem_addr);

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .if_id_instr  (if_id_instr),
        .if_id_pc     (if_id_pc),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign_err (misalign_err),
`endif
        .fetch_count  (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the stage.
    logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4, m_cnt;
    logic        m_valid, m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 32'd0; m_instr <= NOP; m_ifpc <= 32'd0; m_ifpc4 <= 32'd0;
            m_valid <= 1'b0; m_cnt <= 32'd0; m_err <= 1'b0;
        end else if (m_err) begin
            m_valid <= 1'b0;
        end else if (branch_taken) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (branch_target % 4 != 0) m_err <= 1'b1;
            else m_pc <= (branch_target / 4) * 4;
`else
            m_pc <= (branch_target / 4) * 4;
`endif
            m_valid <= 1'b0;
            m_instr <= NOP;
        end else if (!stall) begin
            m_instr <= word(m_pc);
            m_ifpc  <= m_pc;
            m_ifpc4 <= m_pc + 32'd4;
            m_pc    <= m_pc + 32'd4;
            m_valid <= 1'b1;
            m_cnt   <= m_cnt + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc imem_addr", imem_addr, m_pc);
            chk("cyc if_id_instr", if_id_instr, m_instr);
            chk("cyc if_id_pc", if_id_pc, m_ifpc);
            chk("cyc if_id_pc4", if_id_pc4, m_ifpc4);
            chk("cyc if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
            chk("cyc fetch_count", fetch_count, m_cnt);
`ifdef FETCH_MISALIGN_TRAP_EN
            chk("cyc misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
`endif
        end
    end

    task automatic cyc(input logic s, input logic b, input logic [31:0] t);
        stall = s;
        branch_taken = b;
        branch_target = t;
        @(posedge clk);
        #1;
        stall = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1;
        chk("reset imem_addr", imem_addr, 32'd0);
        chk("reset if_id_instr", if_id_instr, NOP);
        chk("reset if_id_valid", {31'd0, if_id_valid}, 32'd0);
        chk("reset fetch_count", fetch_count, 32'd0);
        cmp_en = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        // Sequential fetch after a mid-cycle reset.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 32'd0);
        chk("seq imem_addr", imem_addr, 32'd20);
        chk("seq if_id_pc", if_id_pc, 32'd16);
        chk("seq if_id_instr", if_id_instr, 32'h0010_FFEF);
        chk("seq fetch_count", fetch_count, 32'd5);

        // Stall hold at pc = 8.
        do_reset();
        cyc(1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'd0);
        chk("stall imem_addr", imem_addr, 32'd8);
        chk("stall if_id_pc", if_id_pc, 32'd4);
        chk("stall fetch_count", fetch_count, 32'd2);
        cyc(1'b0, 1'b0, 32'd0);
        chk("unstall if_id_pc", if_id_pc, 32'd8);
        chk("unstall imem_addr", imem_addr, 32'd12);

        // Branch at pc = 12 to 40.
        cyc(1'b0, 1'b1, 32'd40);
        chk("br imem_addr", imem_addr, 32'd40);
        chk("br if_id_valid", {31'd0, if_id_valid}, 32'd0);
        chk("br if_id_instr", if_id_instr, NOP);
        chk("br if_id_pc hold", if_id_pc, 32'd8);
        chk("br fetch_count", fetch_count, 32'd3);
        cyc(1'b0, 1'b0, 32'd0);
        chk("br+1 if_id_pc", if_id_pc, 32'd40);
        chk("br+1 if_id_valid", {31'd0, if_id_valid}, 32'd1);

        // Redirect beats stall, then back-to-back redirects.
        cyc(1'b1, 1'b1, 32'd100);
        chk("brstall imem_addr", imem_addr, 32'd100);
        chk("brstall if_id_valid", {31'd0, if_id_valid}, 32'd0);
        chk("brstall fetch_count", fetch_count, 32'd4);
        cyc(1'b0, 1'b1, 32'd200);
        cyc(1'b0, 1'b1, 32'd300);
        chk("b2b imem_addr", imem_addr, 32'd300);
        chk("b2b fetch_count", fetch_count, 32'd4);

        // PC wrap-around.
        cyc(1'b0, 1'b1, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 32'd0);
        chk("wrap imem_addr", imem_addr, 32'd0);
        chk("wrap if_id_pc", if_id_pc, 32'hFFFF_FFFC);
        chk("wrap if_id_pc4", if_id_pc4, 32'd0);
        chk("wrap fetch_count", fetch_count, 32'd5);

        // Misaligned redirect target.
        cyc(1'b0, 1'b1, 32'd42);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis err", {31'd0, misalign_err}, 32'd1);
        chk("mis imem_addr", imem_addr, 32'd0);
        cyc(1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b1, 32'd64);
        chk("mis frozen imem_addr", imem_addr, 32'd0);
        chk("mis frozen valid", {31'd0, if_id_valid}, 32'd0);
        chk("mis frozen count", fetch_count, 32'd5);
`else
        chk("mis imem_addr", imem_addr, 32'd40);
        cyc(1'b0, 1'b0, 32'd0);
        chk("mis+1 if_id_pc", if_id_pc, 32'd40);
        chk("mis+1 if_id_valid", {31'd0, if_id_valid}, 32'd1);
`endif

        // Reset asserted in the middle of a stall.
        cyc(1'b0, 1'b0, 32'd0);
        stall = 1'b1;
        do_reset();
        chk("rststall imem_addr", imem_addr, 32'd0);
        cyc(1'b1, 1'b0, 32'd0);
        chk("rststall hold count", fetch_count, 32'd0);
        cyc(1'b0, 1'b0, 32'd0);
        chk("rststall fetch pc", if_id_pc, 32'd0);
        chk("rststall fetch instr", if_id_instr, 32'h0000_FFFF);

        @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
